// File: rtl/d_trigger.sv
// Positive-edge D register with async active-high reset and registered per-bit edge flags.
// Define D_TRIGGER_QN_EN to add the combinational Qn = ~Q output.
`timescale 1ns/1ps
module d_trigger #(
  parameter int unsigned            WIDTH       = 1,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_rise,
  output logic [WIDTH-1:0] Q_fall
`ifdef D_TRIGGER_QN_EN
  ,
  output logic [WIDTH-1:0] Qn
`endif
);

  // Flags compare the incoming D against the Q held before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q      <= RESET_VALUE;
      Q_rise <= '0;
      Q_fall <= '0;
    end else begin
      Q      <= D;
      Q_rise <= D & ~Q;
      Q_fall <= ~D & Q;
    end
  end

`ifdef D_TRIGGER_QN_EN
  always_comb begin
    Qn = ~Q;
  end
`endif

endmodule

// File: tb/tb_d_trigger.sv
// Directed bench for d_trigger: a WIDTH=1 instance and a WIDTH=8/RESET_VALUE=8'hA5 instance
// checked every cycle against a captured-value history, plus literal spot checks.
`timescale 1ns/1ps
module tb_d_trigger;

  logic       clk = 1'b0;
  logic       rst;
  logic       d1;
  logic [7:0] d8;
  logic       q1, rise1, fall1;
  logic [7:0] q8, rise8, fall8;
`ifdef D_TRIGGER_QN_EN
  logic       qn1;
  logic [7:0] qn8;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  d_trigger #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .D(d1), .Q(q1), .Q_rise(rise1), .Q_fall(fall1)
`ifdef D_TRIGGER_QN_EN
    , .Qn(qn1)
`endif
  );

  d_trigger #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
    .clk(clk), .rst(rst), .D(d8), .Q(q8), .Q_rise(rise8), .Q_fall(fall8)
`ifdef D_TRIGGER_QN_EN
    , .Qn(qn8)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  // Model: history of values Q has held. Reset loads RESET_VALUE twice so that
  // "previous" equals "current" and no edge is implied.
  logic       hist1[$];
  logic [7:0] hist8[$];

  always @(posedge rst) begin
    hist1 = '{1'b0, 1'b0};
    hist8 = '{8'hA5, 8'hA5};
  end

  always @(posedge clk) begin
    if (!rst) begin
      hist1.push_back(d1);
      hist8.push_back(d8);
    end
  end

  always @(negedge clk) begin
    int unsigned n1, n8;
    n1 = hist1.size();
    n8 = hist8.size();
    if (n1 >= 1) begin
      check("model_q1", 64'(q1), 64'(hist1[n1-1]));
`ifdef D_TRIGGER_QN_EN
      check("model_qn1", 64'(qn1), 64'(~hist1[n1-1]));
`endif
    end
    if (n1 >= 2) begin
      check("model_rise1", 64'(rise1), 64'(hist1[n1-1] & ~hist1[n1-2]));
      check("model_fall1", 64'(fall1), 64'(~hist1[n1-1] & hist1[n1-2]));
    end
    if (n8 >= 1) begin
      check("model_q8", 64'(q8), 64'(hist8[n8-1]));
`ifdef D_TRIGGER_QN_EN
      check("model_qn8", 64'(qn8), 64'(~hist8[n8-1]));
`endif
    end
    if (n8 >= 2) begin
      check("model_rise8", 64'(rise8), 64'(hist8[n8-1] & ~hist8[n8-2]));
      check("model_fall8", 64'(fall8), 64'(~hist8[n8-1] & hist8[n8-2]));
    end
  end

  logic [7:0] tbl [6] = '{8'hFF, 8'h00, 8'h3C, 8'hC3, 8'hC3, 8'h81};

  initial begin
    rst = 1'b0; d1 = 1'b0; d8 = 8'h00;
    #6;  check("cap_t6_q", 64'(q1), 64'd0);
    #4;  d1 = 1'b1; d8 = 8'h0F;
    #6;  check("cap_t16_q", 64'(q1), 64'd1);
         check("cap_t16_rise", 64'(rise1), 64'd1);
         check("cap_t16_fall", 64'(fall1), 64'd0);
    #10; check("cap_t26_q", 64'(q1), 64'd1);
         check("cap_t26_rise", 64'(rise1), 64'd0);
    #4;  d1 = 1'b0; d8 = 8'hF0;
    #6;  check("cap_t36_q", 64'(q1), 64'd0);
         check("cap_t36_fall", 64'(fall1), 64'd1);
         check("cap_t36_rise", 64'(rise1), 64'd0);
    #10; check("cap_t46_q", 64'(q1), 64'd0);
         check("cap_t46_fall", 64'(fall1), 64'd0);
    // Glitch between edges 45 and 55
    #2;  d1 = 1'b1; d8 = 8'hFF;
    #2;  d1 = 1'b0; d8 = 8'hF0;
    #6;  check("glitch_q", 64'(q1), 64'd0);
         check("glitch_rise", 64'(rise1), 64'd0);
         check("glitch_fall", 64'(fall1), 64'd0);
         check("glitch_q8", 64'(q8), 64'hF0);
    #2;  d1 = 1'b1;
    #8;  check("pre_rst_q", 64'(q1), 64'd1);
    // Async reset mid-cycle at t67
    #1;  rst = 1'b1; d8 = 8'h5A;
    #1;  check("rst_async_q", 64'(q1), 64'd0);
         check("rst_async_rise", 64'(rise1), 64'd0);
         check("rst_async_fall", 64'(fall1), 64'd0);
         check("rst_async_q8", 64'(q8), 64'hA5);
         check("rst_async_rise8", 64'(rise8), 64'h00);
    #18; check("rst_hold_q", 64'(q1), 64'd0);
         check("rst_hold_q8", 64'(q8), 64'hA5);
`ifdef D_TRIGGER_QN_EN
         check("rst_hold_qn8", 64'(qn8), 64'h5A);
         check("rst_hold_qn1", 64'(qn1), 64'd1);
`endif
    // Release at t92 with clk low; edge at 95 captures D
    #6;  rst = 1'b0;
    #4;  check("rel_q8", 64'(q8), 64'h5A);
         check("rel_rise8", 64'(rise8), 64'h5A);
         check("rel_fall8", 64'(fall8), 64'hA5);
         check("rel_q1", 64'(q1), 64'd1);
         check("rel_rise1", 64'(rise1), 64'd1);
    #6;
    for (int i = 0; i < 6; i++) begin
      d8 = tbl[i];
      d1 = tbl[i][0];
      #10;
    end
    check("tbl_q8", 64'(q8), 64'h81);
    check("tbl_rise8", 64'(rise8), 64'h00);
    check("tbl_fall8", 64'(fall8), 64'h42);
    check("tbl_rise1", 64'(rise1), 64'd0);
    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
